// File: rtl/simple_axi_pkg.sv
// Shared AXI subset definitions used by the simple master and slave blocks.
package simple_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } transfer_size_e;

  // Low address bits that must be zero for a transfer of the given size.
  function automatic logic [2:0] align_mask(input logic [2:0] size);
    case (transfer_size_e'(size))
      BYTE:    return 3'b000;
      HALF:    return 3'b001;
      WORD:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/simple_axi_slave_ram.sv
// DEPTH x 64-bit RAM with per-byte write enables and a registered read port.
module simple_axi_slave_ram
  import simple_axi_pkg::*;
#(
  parameter int unsigned DEPTH = 512
) (
  input  logic                     i_clk,
  input  logic [STRB_W-1:0]        we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/simple_axi_slave_mem.sv
// Single-outstanding AXI4 subset responder: single-beat writes and reads
// into a byte-enabled 64-bit RAM, with DECERR/SLVERR reporting.
module simple_axi_slave_mem
  import simple_axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awsize,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic              s_axi_wlast,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arsize,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              s_axi_rlast,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam logic [32:0] WINDOW = 33'(DEPTH) * 33'd8;

  typedef enum logic [1:0] {S_IDLE, S_W_DATA, S_W_RESP, S_R_DATA} state_e;

  state_e           state_q, state_d;
  axi_resp_e        resp_q, resp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lat_en;
  logic             idle_q, wready_q, bvalid_q, rvalid_q;
  logic [STRB_W-1:0] ram_we;
  logic             ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic             aw_hs, ar_hs, w_hs;

  // Out-of-window beats decoding errors; misalignment only matters inside the window.
  function automatic axi_resp_e decode_resp(input logic [ADDR_W-1:0] addr, input logic [2:0] size);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    if ({1'b0, off} >= WINDOW)                   return DECERR;
    else if (size > 3'd3)                        return SLVERR;
    else if ((addr[2:0] & align_mask(size)) != 3'b000) return SLVERR;
    else                                         return OKAY;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    logic [IDX_W+2:0] off;
    off = (IDX_W+3)'(addr - BASE_ADDR);
    return off[IDX_W+2:3];
  endfunction

  assign aw_hs = idle_q & s_axi_awvalid;
  assign ar_hs = s_axi_arready & s_axi_arvalid;
  assign w_hs  = wready_q & s_axi_wvalid;

  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    idx_d   = idx_q;
    lat_en  = 1'b0;
    ram_we  = '0;
    ram_re  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          state_d = S_W_DATA;
          lat_en  = 1'b1;
          resp_d  = decode_resp(s_axi_awaddr, s_axi_awsize);
          idx_d   = word_idx(s_axi_awaddr);
        end else if (ar_hs) begin
          state_d = S_R_DATA;
          lat_en  = 1'b1;
          resp_d  = decode_resp(s_axi_araddr, s_axi_arsize);
          idx_d   = word_idx(s_axi_araddr);
          ram_re  = 1'b1;
        end
      end
      S_W_DATA: begin
        if (w_hs) begin
          state_d = S_W_RESP;
          if (resp_q == OKAY) ram_we = s_axi_wstrb;
        end
      end
      S_W_RESP: if (bvalid_q && s_axi_bready) state_d = S_IDLE;
      S_R_DATA: if (rvalid_q && s_axi_rready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State plus registered handshake flags derived from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      resp_q   <= OKAY;
      idx_q    <= '0;
      idle_q   <= 1'b0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == S_IDLE);
      wready_q <= (state_d == S_W_DATA);
      bvalid_q <= (state_d == S_W_RESP);
      rvalid_q <= (state_d == S_R_DATA);
      if (lat_en) begin
        resp_q <= resp_d;
        idx_q  <= idx_d;
      end
    end
  end

  simple_axi_slave_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk (i_clk),
    .we    (ram_we),
    .waddr (idx_q),
    .wdata (s_axi_wdata),
    .re    (ram_re),
    .raddr (idx_d),
    .rdata (ram_rdata)
  );

  assign s_axi_awready = idle_q;
  assign s_axi_arready = idle_q & ~s_axi_awvalid;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = resp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rvalid_q;
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = (rvalid_q && resp_q == OKAY) ? ram_rdata : '0;

  logic unused_wlast;
  assign unused_wlast = s_axi_wlast;

endmodule

// File: tb/tb_simple_axi_slave_mem.sv
// Scoreboard bench for simple_axi_slave_mem: drivers queue expected B/R
// responses, a negedge monitor pops and compares on each handshake.
module tb_simple_axi_slave_mem;

  localparam int unsigned DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        i_clk, i_rst;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [2:0]  s_axi_awsize;
  logic        s_axi_wvalid, s_axi_wready, s_axi_wlast;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [2:0]  s_axi_arsize;
  logic        s_axi_rvalid, s_axi_rready, s_axi_rlast;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;

  simple_axi_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awsize(s_axi_awsize),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wlast(s_axi_wlast), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arsize(s_axi_arsize),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rlast(s_axi_rlast),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp)
  );

  localparam logic [1:0] R_OKAY = 2'b00, R_SLVERR = 2'b10, R_DECERR = 2'b11;

  typedef struct {
    bit          is_read;
    logic [1:0]  resp;
    logic [63:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Response monitor: sampled mid-cycle, compares whatever handshake is about to fire.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (s_axi_bvalid && s_axi_bready) begin
        if (sb.size() == 0) check("b_unexpected", 64'(s_axi_bresp), 64'hFFFF);
        else begin
          mon_e = sb.pop_front();
          check("b_kind", 64'(mon_e.is_read), 64'd0);
          check("bresp", 64'(s_axi_bresp), 64'(mon_e.resp));
        end
      end
      if (s_axi_rvalid && s_axi_rready) begin
        if (sb.size() == 0) check("r_unexpected", 64'(s_axi_rresp), 64'hFFFF);
        else begin
          mon_e = sb.pop_front();
          check("r_kind", 64'(mon_e.is_read), 64'd1);
          check("rresp", 64'(s_axi_rresp), 64'(mon_e.resp));
          check("rdata", s_axi_rdata, mon_e.data);
          check("rlast", 64'(s_axi_rlast), 64'd1);
        end
      end
    end
  end

  task automatic do_aw(input logic [31:0] addr, input logic [2:0] size);
    int n = 0;
    s_axi_awaddr = addr; s_axi_awsize = size; s_axi_awvalid = 1'b1;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    check("awready", 64'(s_axi_awready), 64'd1);
    tick();
    s_axi_awvalid = 1'b0;
    check("wready_latency", 64'(s_axi_wready), 64'd1);
  endtask

  task automatic do_w(input logic [63:0] data, input logic [7:0] strb);
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
    tick();
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid_latency", 64'(s_axi_bvalid), 64'd1);
  endtask

  task automatic do_b(input logic [1:0] resp, input int stall);
    sb.push_back('{1'b0, resp, 64'h0});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("bvalid_hold", 64'(s_axi_bvalid), 64'd1);
      check("bresp_hold", 64'(s_axi_bresp), 64'(resp));
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic do_ar(input logic [31:0] addr, input logic [2:0] size);
    int n = 0;
    s_axi_araddr = addr; s_axi_arsize = size; s_axi_arvalid = 1'b1;
    #1;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    check("arready", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check("rvalid_latency", 64'(s_axi_rvalid), 64'd1);
  endtask

  task automatic do_r(input logic [1:0] resp, input logic [63:0] data, input int stall);
    sb.push_back('{1'b1, resp, data});
    for (int i = 0; i < stall; i++) begin
      tick();
      check("rdata_hold", s_axi_rdata, data);
    end
    s_axi_rready = 1'b1;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic write(input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data,
                       input logic [7:0] strb, input logic [1:0] resp, input int stall);
    do_aw(addr, size);
    do_w(data, strb);
    do_b(resp, stall);
  endtask

  task automatic read(input logic [31:0] addr, input logic [2:0] size, input logic [1:0] resp,
                      input logic [63:0] data, input int stall);
    do_ar(addr, size);
    do_r(resp, data, stall);
  endtask

  initial begin
    i_rst = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awsize = '0;
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arsize = '0;
    s_axi_rready = 1'b0;
    #2;
    check("reset_ctrl", 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                              s_axi_rvalid, s_axi_rlast, s_axi_rresp}), 64'd0);
    check("reset_rdata", s_axi_rdata, 64'd0);
    repeat (3) tick();
    i_rst = 1'b0;
    repeat (2) tick();

    // Dword write with a stalled B, then readback with a stalled R.
    write(32'h1000_0008, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, R_OKAY, 5);
    read (32'h1000_0008, 3'd3, R_OKAY, 64'h0123_4567_89AB_CDEF, 3);

    // Single-byte strobe into lane 3.
    write(32'h1000_000B, 3'd0, 64'h0000_0000_5A00_0000, 8'h08, R_OKAY, 0);
    read (32'h1000_0008, 3'd3, R_OKAY, 64'h0123_4567_5AAB_CDEF, 0);

    // Word 0 known value; out-of-window and misaligned accesses must not touch it.
    write(32'h1000_0000, 3'd3, 64'h1111_2222_3333_4444, 8'hFF, R_OKAY, 0);
    write(32'h1000_1000, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, R_DECERR, 0);
    read (32'h1000_0002, 3'd2, R_SLVERR, 64'h0, 2);
    write(32'h1000_0002, 3'd2, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, R_SLVERR, 0);
    read (32'h1000_0000, 3'd3, R_OKAY, 64'h1111_2222_3333_4444, 0);
    read (32'h0FFF_FFF8, 3'd3, R_DECERR, 64'h0, 0);
    read (32'h1000_0000, 3'd4, R_SLVERR, 64'h0, 0);

    // Last word of the window, half-word write into it.
    write(32'h1000_0FF8, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, R_OKAY, 0);
    write(32'h1000_0FFE, 3'd1, 64'hBEEF_0000_0000_0000, 8'hC0, R_OKAY, 0);
    read (32'h1000_0FF8, 3'd3, R_OKAY, 64'hBEEF_A5A5_A5A5_A5A5, 0);

    // Simultaneous AW and AR: write goes first, read follows the B handshake.
    s_axi_awaddr = 32'h1000_0018; s_axi_awsize = 3'd3; s_axi_awvalid = 1'b1;
    s_axi_araddr = 32'h1000_0018; s_axi_arsize = 3'd3; s_axi_arvalid = 1'b1;
    #1;
    check("prio_awready", 64'(s_axi_awready), 64'd1);
    check("prio_arready", 64'(s_axi_arready), 64'd0);
    tick();
    s_axi_awvalid = 1'b0;
    check("prio_wready", 64'(s_axi_wready), 64'd1);
    check("prio_arready_busy", 64'(s_axi_arready), 64'd0);
    do_w(64'hCAFE_F00D_1234_5678, 8'hFF);
    do_b(R_OKAY, 0);
    check("b2b_arready", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check("prio_rvalid", 64'(s_axi_rvalid), 64'd1);
    do_r(R_OKAY, 64'hCAFE_F00D_1234_5678, 0);

    // Asynchronous reset while waiting for write data.
    do_aw(32'h1000_0008, 3'd3);
    s_axi_wdata = 64'hFFFF_FFFF_FFFF_FFFF; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_ctrl", 64'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                               s_axi_rvalid, s_axi_rlast, s_axi_rresp}), 64'd0);
    check("midrst_rdata", s_axi_rdata, 64'd0);
    s_axi_wvalid = 1'b0;
    repeat (2) tick();
    i_rst = 1'b0;
    repeat (2) tick();
    read (32'h1000_0008, 3'd3, R_OKAY, 64'h0123_4567_5AAB_CDEF, 0);
    write(32'h1000_0020, 3'd2, 64'h0000_0000_7777_8888, 8'h0F, R_OKAY, 0);
    write(32'h1000_0024, 3'd2, 64'h9999_AAAA_0000_0000, 8'hF0, R_OKAY, 0);
    read (32'h1000_0020, 3'd3, R_OKAY, 64'h9999_AAAA_7777_8888, 0);

    repeat (3) tick();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/simple_axi_slave_mem.md
Name: simple_axi_slave_mem

Overview:
Single-outstanding AXI4 subset responder backed by a 64-bit-wide byte-enabled RAM; the memory-side counterpart of the team's simple AXI master. Serves single-beat writes (AW, W, B) and reads (AR, R) with sizes from byte to dword. Returns DECERR for addresses outside its window and SLVERR for misaligned or illegal-size requests. Used as the bench target and on-chip scratch memory.

Parameters:
DEPTH, 512, number of 64-bit words; power of two, >= 2.
BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to DEPTH*8.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_awaddr  in  32  write byte address
s_axi_awsize  in  3  write size; 0 = byte, 1 = half, 2 = word, 3 = dword
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_wlast  in  1  last beat; ignored, every beat is single
s_axi_wdata  in  64  lane-positioned write data
s_axi_wstrb  in  8  byte enables
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_bresp  out  2  write response
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  32  read byte address
s_axi_arsize  in  3  read size
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rlast  out  1  equals s_axi_rvalid
s_axi_rdata  out  64  full 64-bit word, lane-positioned
s_axi_rresp  out  2  read response

Behaviour:
- Clock and reset: single clock i_clk. i_rst is asynchronous and active-high.
- Reset state: all outputs 0, FSM in S_IDLE, latched address, size and response cleared. RAM contents are not reset.
- FSM states: S_IDLE, S_W_DATA, S_W_RESP, S_R_DATA. A reset asserted in any state drops any pending transaction and returns the FSM to S_IDLE.
- S_IDLE: s_axi_awready = 1. s_axi_arready = !s_axi_awvalid, so write wins when awvalid and arvalid are both high. All other readies and valids are 0.
- AW handshake: latch awaddr and awsize, compute the response, go to S_W_DATA.
- AR handshake: latch the address, compute the response, go to S_R_DATA.
- Response code: DECERR (2'b11) if (addr - BASE_ADDR) >= DEPTH*8. Otherwise SLVERR (2'b10) if size > 3 or addr is not aligned to 2^size. Otherwise OKAY (2'b00). DECERR takes precedence over SLVERR.
- Word index: (addr - BASE_ADDR) >> 3, truncated to clog2(DEPTH) bits.
- S_W_DATA: s_axi_wready = 1.
  - On W handshake with resp OKAY, each RAM byte i is written from wdata[8i+7:8i] where wstrb[i] = 1.
  - On error, nothing is written.
  - The FSM goes to S_W_RESP on the next cycle.
- S_W_RESP: s_axi_bvalid = 1 and s_axi_bresp = latched response, held stable until bready. On the B handshake the FSM goes to S_IDLE.
- S_R_DATA: s_axi_rvalid = s_axi_rlast = 1.
  - s_axi_rdata = RAM word captured at the AR handshake on OKAY, otherwise 0.
  - s_axi_rresp = latched response. rdata and rresp are held stable until rready.
  - On the R handshake the FSM goes to S_IDLE.
- Latency:
  - AW handshake at cycle N: wready = 1 at N+1.
  - W handshake at cycle M: bvalid = 1 at M+1.
  - AR handshake at cycle N: rvalid = 1 at N+1.
  - Minimum write is 3 cycles; minimum read is 2 cycles.
- Single outstanding transaction: awready and arready stay 0 outside S_IDLE. Early wvalid (before AW) is not accepted and simply waits.
- Back-to-back: a new AW or AR can be accepted in the cycle after the B or R handshake.
- RAM read data is registered. There is no read-during-write hazard because only one transaction is in flight.

Decomposition:
- Shared package simple_axi_pkg: axi_resp_e (OKAY, EXOKAY, SLVERR, DECERR) and transfer_size_e (BYTE, HALF, WORD, DWORD), so master and slave use common enums.
- One sub-module: simple_axi_slave_ram, a DEPTH x 64-bit RAM with 8 byte-write-enables, one write port and a registered read port.
- Address decode, error check and FSM stay in the top module.

Test Plan:
- Dword write then read: write 0x1000_0008 size 3 data 0x0123_4567_89AB_CDEF strb 0xFF, then read the same address. Required: bresp = OKAY and bvalid one cycle after the W handshake; rdata = 0x0123_4567_89AB_CDEF, rresp = OKAY, rlast = 1. Run with BASE_ADDR = 0x1000_0000.
- Byte strobe write: after the dword write above, write the byte at 0x1000_000B with wdata 0x0000_0000_5A00_0000 and strb 0x08. Required: readback of 0x1000_0008 = 0x0123_4567_5AAB_CDEF.
- Error responses: write to BASE + DEPTH*8 gets bresp = DECERR. Read of a word at address 0x1000_0002 gets rresp = SLVERR and rdata = 0. Neither request changes the RAM.
- Stalls and priority:
  - Hold bready = 0 for 5 cycles: bvalid and bresp stay stable.
  - Hold rready = 0: rdata stays stable.
  - Assert awvalid and arvalid together: AW is accepted first, AR after the B handshake.
- Reset mid-transaction: assert i_rst asynchronously in S_W_DATA. Required: all outputs are 0 immediately, and the next AW is accepted normally.
